// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit producing HI/LO with a start/busy/done handshake.
// Define MULDIV_RADIX4_EN for a 2-bit-per-cycle multiply; divide always retires 1 bit per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef MULDIV_RADIX4_EN
    localparam int MUL_CYC = WIDTH / 2;
`else
    localparam int MUL_CYC = WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mb;
    // multiply: {accumulator, multiplier}; divide: low half is dividend shifting into quotient
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   ma_in;
    logic [WIDTH-1:0]   mb_in;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     sub;
    logic               fits;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        sa       = ~op[0] & a[WIDTH-1];
        sb       = ~op[0] & b[WIDTH-1];
        ma_in    = sa ? -a : a;
        mb_in    = sb ? -b : b;
        trial    = {rem, prod[WIDTH-1]};
        sub      = trial - {1'b0, mb};
        // trial < 2*mb always, so a non-negative difference never sets the top bit
        fits     = ~sub[WIDTH];
        prod_fix = neg_q ? -prod : prod;
        q_fix    = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        r_fix    = neg_r ? -rem : rem;
`ifdef MULDIV_RADIX4_EN
        mul_next = {({2'b0, prod[2*WIDTH-1:WIDTH]} + {2'b0, mb} * {{WIDTH{1'b0}}, prod[1:0]}),
                    prod[WIDTH-1:2]};
`else
        mul_next = {({1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mb} : '0)),
                    prod[WIDTH-1:1]};
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            cnt         <= '0;
            mb          <= '0;
            prod        <= '0;
            rem         <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    is_div <= op[1];
                    neg_q  <= sa ^ sb;
                    neg_r  <= sa;
                    mb     <= mb_in;
                    prod   <= {{WIDTH{1'b0}}, ma_in};
                    rem    <= '0;
                    cnt    <= op[1] ? CW'(WIDTH) : CW'(MUL_CYC);
                    if (op[1] && b == '0) begin
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                        state       <= DONE;
                    end else begin
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        rem              <= fits ? sub[WIDTH-1:0] : trial[WIDTH-1:0];
                        prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], fits};
                    end else begin
                        prod <= mul_next;
                    end
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    hi    <= is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo    <= is_div ? q_fix : prod_fix[WIDTH-1:0];
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
